// File: rtl/rll_key_stream_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rll_key_stream_unit
//  Description : Serial-loaded, atomically committed RLL key applied as a
//                per-bit XOR/XNOR key-gate layer on a registered valid/ready
//                stream. Optional macro RLL_KEY_PARITY_EN adds a trailing
//                even-parity bit to every key load (mismatch -> key_err).
//  Revision    : 1.0 - initial release
// ============================================================================
module rll_key_stream_unit #(
    parameter int                KEY_W    = 32,
    parameter int                DATA_W   = 32,
    parameter logic [KEY_W-1:0]  GATE_POL = {KEY_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_sin,
    input  logic              key_sin_valid,
    input  logic              key_clear,
    output logic              key_loaded,
    output logic              key_busy,
    output logic              key_err,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int                 c_CNT_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(KEY_W - 1);

    typedef enum logic [1:0] {
        K_IDLE  = 2'd0,
`ifdef RLL_KEY_PARITY_EN
        K_SHIFT = 2'd1,
        K_PAR   = 2'd2
`else
        K_SHIFT = 2'd1
`endif
    } key_state_t;

    key_state_t          r_state,  w_state_nxt;
    logic [KEY_W-1:0]    r_shadow, w_shadow_nxt;
    logic [KEY_W-1:0]    w_shadow_ins;
    logic [c_CNT_W-1:0]  r_cnt,    w_cnt_nxt;
    logic [KEY_W-1:0]    r_active, w_active_nxt;
    logic                r_loaded, w_loaded_nxt;
`ifdef RLL_KEY_PARITY_EN
    logic                r_err,    w_err_nxt;
`endif

    logic [KEY_W-1:0]    w_eff;
    logic [DATA_W-1:0]   w_mask;
    logic                w_xfer;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;

    // Key FSM state and key registers; everything drops at once on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= K_IDLE;
            r_shadow <= '0;
            r_cnt    <= '0;
            r_active <= '0;
            r_loaded <= 1'b0;
`ifdef RLL_KEY_PARITY_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_shadow <= w_shadow_nxt;
            r_cnt    <= w_cnt_nxt;
            r_active <= w_active_nxt;
            r_loaded <= w_loaded_nxt;
`ifdef RLL_KEY_PARITY_EN
            r_err    <= w_err_nxt;
`endif
        end
    end

    // Next-state logic: key_clear wins, otherwise shift bits in at the
    // counter index and commit the whole shadow on the final bit
    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow;
        w_cnt_nxt    = r_cnt;
        w_active_nxt = r_active;
        w_loaded_nxt = r_loaded;
`ifdef RLL_KEY_PARITY_EN
        w_err_nxt    = 1'b0;
`endif
        // Shadow with the incoming bit placed at the current position
        w_shadow_ins        = r_shadow;
        w_shadow_ins[r_cnt] = key_sin;

        if (key_clear) begin
            w_state_nxt  = K_IDLE;
            w_shadow_nxt = '0;
            w_cnt_nxt    = '0;
            w_active_nxt = '0;
            w_loaded_nxt = 1'b0;
        end else begin
            case (r_state)
                // The counter is always zero in K_IDLE, so the first bit lands
                // in shadow[0]; with KEY_W = 1 that bit is also the last one
                K_IDLE, K_SHIFT: begin
                    if (key_sin_valid) begin
                        w_shadow_nxt = w_shadow_ins;
                        if (r_cnt == c_LAST) begin
                            w_cnt_nxt = '0;
`ifdef RLL_KEY_PARITY_EN
                            w_state_nxt  = K_PAR;
`else
                            w_active_nxt = w_shadow_ins;
                            w_loaded_nxt = 1'b1;
                            w_shadow_nxt = '0;
                            w_state_nxt  = K_IDLE;
`endif
                        end else begin
                            w_cnt_nxt   = r_cnt + c_CNT_W'(1);
                            w_state_nxt = K_SHIFT;
                        end
                    end
                end
`ifdef RLL_KEY_PARITY_EN
                // Trailing bit must equal the even parity of the shadow;
                // a mismatch leaves the active key untouched
                K_PAR: begin
                    if (key_sin_valid) begin
                        if (key_sin == (^r_shadow)) begin
                            w_active_nxt = r_shadow;
                            w_loaded_nxt = 1'b1;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                        w_shadow_nxt = '0;
                        w_state_nxt  = K_IDLE;
                    end
                end
`endif
                default: begin
                    w_state_nxt  = K_IDLE;
                    w_shadow_nxt = '0;
                    w_cnt_nxt    = '0;
                end
            endcase
        end
    end

    assign key_loaded = r_loaded;
    assign key_busy   = (r_state != K_IDLE);
`ifdef RLL_KEY_PARITY_EN
    assign key_err    = r_err;
`else
    assign key_err    = 1'b0;
`endif

    // Effective key: gate polarity folded in, so an uncommitted (zero) key
    // still gates data with GATE_POL alone
    assign w_eff = r_active ^ GATE_POL;

    // Replicate the effective key across the data word (bit i <- key i mod KEY_W)
    for (genvar i = 0; i < DATA_W; i++) begin : g_mask
        assign w_mask[i] = w_eff[i % KEY_W];
    end

    assign in_ready = !r_out_valid || out_ready;
    assign w_xfer   = in_valid && in_ready;

    // Output stage: key sampled at capture, word held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_xfer) begin
            r_out_data  <= in_data ^ w_mask;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_rll_key_stream_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rll_key_stream_unit
//  Description : Self-checking bench for rll_key_stream_unit (KEY_W = DATA_W
//                = 32, GATE_POL = 0). Expected words are queued at capture
//                and compared when the output handshake completes.
//                Parity scenarios are built when RLL_KEY_PARITY_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rll_key_stream_unit;

    localparam int          c_KEY_W  = 32;
    localparam int          c_DATA_W = 32;
    localparam logic [31:0] c_POL    = 32'h0;

    logic              clk;
    logic              rst_n;
    logic              key_sin;
    logic              key_sin_valid;
    logic              key_clear;
    logic              key_loaded;
    logic              key_busy;
    logic              key_err;
    logic [31:0]       in_data;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready;

    int                n_chk;
    int                n_err;
    logic [31:0]       model_key;
    logic [31:0]       sb_q[$];
    logic              prev_stall;
    logic [31:0]       prev_data;

    rll_key_stream_unit #(
        .KEY_W    (c_KEY_W),
        .DATA_W   (c_DATA_W),
        .GATE_POL (c_POL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_sin       (key_sin),
        .key_sin_valid (key_sin_valid),
        .key_clear     (key_clear),
        .key_loaded    (key_loaded),
        .key_busy      (key_busy),
        .key_err       (key_err),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Scoreboard: pop on completed output handshake, watch stall stability,
    // push the expected word on every input capture
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) check("sb_unexpected", out_data, 32'hxxxx_xxxx);
                else check("sb_data", out_data, sb_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_valid && in_ready)
                sb_q.push_back(in_data ^ model_key ^ c_POL);
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_word(input logic [31:0] d);
        logic ok;
        int   n;
        in_data  = d;
        in_valid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!ok && n > 200) begin
                check("send_timeout", 32'd1, 32'd0);
                ok = 1'b1;
            end
        end
    endtask

    task automatic send_key_bit(input logic b);
        key_sin       = b;
        key_sin_valid = 1'b1;
        @(posedge clk);
        #1;
        key_sin_valid = 1'b0;
    endtask

    // Full load LSB first with 0-3 idle cycles between bits; the parity
    // build appends the even-parity bit
    task automatic load_key(input logic [31:0] k);
        for (int i = 0; i < c_KEY_W; i++) begin
            send_key_bit(k[i]);
            if (i == 0) check("busy_during_load", {31'd0, key_busy}, 32'd1);
            if (i != c_KEY_W - 1) repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
        end
`ifdef RLL_KEY_PARITY_EN
        check("busy_before_parity", {31'd0, key_busy}, 32'd1);
        send_key_bit(^k);
`endif
        model_key = k;
        check("loaded_after_commit", {31'd0, key_loaded}, 32'd1);
        check("idle_after_commit", {31'd0, key_busy}, 32'd0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", sb_q.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        n_chk = 0; n_err = 0; model_key = '0;
        rst_n = 1'b0; key_sin = 1'b0; key_sin_valid = 1'b0; key_clear = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        prev_stall = 1'b0; prev_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_key_loaded", {31'd0, key_loaded}, 32'd0);
        check("rst_key_busy", {31'd0, key_busy}, 32'd0);
        check("rst_key_err", {31'd0, key_err}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_data", out_data, 32'd0);

        // No key: data passes through gated by GATE_POL only
        send_word(32'h12345678);
        in_valid = 1'b0;
        check("nokey_out_valid", {31'd0, out_valid}, 32'd1);
        check("nokey_out_data", out_data, 32'h12345678);
        wait_drain();

        // Key load with idle gaps, then gate a word
        load_key(32'hA5A5A5A5);
        send_word(32'h0000FFFF);
        in_valid = 1'b0;
        check("key_a5_out_data", out_data, 32'hA5A55A5A);
        wait_drain();

        // Full-throughput streaming: four words in four cycles
        t0 = 0;
        for (int i = 0; i < 4; i++) begin
            send_word(32'h1000 + i);
            t0++;
        end
        in_valid = 1'b0;
        wait_drain();

        // Backpressure mid-stream
        load_key(32'hFFFFFFFF);
        fork
            begin
                for (int i = 0; i < 4; i++) send_word(i);
                in_valid = 1'b0;
            end
            begin
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Clear coincident with bit 10 of a new load
        for (int i = 0; i < 10; i++) send_key_bit(1'b1);
        key_sin = 1'b1; key_sin_valid = 1'b1; key_clear = 1'b1;
        @(posedge clk);
        #1;
        key_sin_valid = 1'b0; key_clear = 1'b0;
        model_key = '0;
        check("clear_key_loaded", {31'd0, key_loaded}, 32'd0);
        check("clear_key_busy", {31'd0, key_busy}, 32'd0);
        send_word(32'hCAFEF00D);
        in_valid = 1'b0;
        check("clear_out_data", out_data, 32'hCAFEF00D);
        wait_drain();
        load_key(32'h3C3C1234);
        send_word(32'h00000000);
        in_valid = 1'b0;
        check("reload_out_data", out_data, 32'h3C3C1234);
        wait_drain();

        // Re-key while a word sits stalled in the output register
        load_key(32'h0000000F);
        out_ready = 1'b0;
        send_word(32'h00000000);
        in_valid = 1'b0;
        load_key(32'h000000F0);
        check("rekey_stalled_word", out_data, 32'h0000000F);
        in_data  = 32'h00000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rekey_next_word", out_data, 32'h000000F0);
        wait_drain();

`ifdef RLL_KEY_PARITY_EN
        // Bad parity: error pulse, previous key kept
        for (int i = 0; i < c_KEY_W; i++) send_key_bit(i == 0);
        send_key_bit(1'b0);
        check("par_err_pulse", {31'd0, key_err}, 32'd1);
        check("par_err_loaded", {31'd0, key_loaded}, 32'd1);
        @(posedge clk); #1;
        check("par_err_clears", {31'd0, key_err}, 32'd0);
        send_word(32'h00000000);
        in_valid = 1'b0;
        check("par_err_key_kept", out_data, 32'h000000F0);
        wait_drain();
        // Good parity commits
        load_key(32'h00000001);
        check("par_ok_no_err", {31'd0, key_err}, 32'd0);
        send_word(32'h00000000);
        in_valid = 1'b0;
        check("par_ok_out_data", out_data, 32'h00000001);
        wait_drain();
`endif

        // Reset mid-load discards the partial key and the committed one
        send_key_bit(1'b1);
        send_key_bit(1'b0);
        rst_n = 1'b0;
        #1;
        check("async_rst_loaded", {31'd0, key_loaded}, 32'd0);
        check("async_rst_busy", {31'd0, key_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_key = '0;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rll_key_stream_unit.md
Name: rll_key_stream_unit

Overview:
- Sequential, parametrised successor to our fixed 32-key-gate combinational random-logic-locking (RLL) netlists.
- Loads the key serially through an FSM into a shadow register, then commits it atomically to an active key register.
- Applies the key as a per-bit XOR/XNOR key-gate layer on a registered valid/ready data stream.
- Sits between the tamper-proof key source and the locked datapath; one instance per locked channel.

Parameters:
- KEY_W, 32, number of key bits and key gates (1..256).
- DATA_W, 32, data width; data bit i is gated by key bit (i mod KEY_W).
- GATE_POL, {KEY_W{1'b0}}, per-key-bit gate type: 0 = XOR, 1 = XNOR.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- key_sin  in  1  serial key bit, LSB first
- key_sin_valid  in  1  key_sin carries a valid bit this cycle
- key_clear  in  1  one-cycle pulse: drop the active key and abort any load
- key_loaded  out  1  active key register holds a committed key
- key_busy  out  1  serial load in progress
- key_err  out  1  one-cycle pulse: load rejected (parity feature only)
- in_data  in  DATA_W  input word
- in_valid  in  1  input handshake valid
- in_ready  out  1  input handshake ready
- out_data  out  DATA_W  key-gated word
- out_valid  out  1  output handshake valid
- out_ready  in  1  output handshake ready

Behaviour:
- Reset (async assert, synchronous-release usage assumed by integrator): shadow = 0, active key = 0, bit counter = 0, FSM = K_IDLE, key_loaded = 0, key_busy = 0, key_err = 0, out_valid = 0, out_data = 0.
- Key FSM states:
  - K_IDLE: key_sin_valid=1 → shift bit into shadow[0], counter = 1, go to K_SHIFT. If KEY_W = 1, commit immediately instead.
  - K_SHIFT: each key_sin_valid shifts the shadow right-in at index = counter. Idle cycles are allowed and do not time out.
  - On the KEY_W-th bit: commit shadow → active key, set key_loaded = 1, go to K_IDLE. The commit is visible to data captured on the next cycle.
  - K_PAR: parity feature only (see Optional Feature).
- key_busy = 1 in K_SHIFT/K_PAR.
- key_clear has priority over everything in the same cycle: active key = 0, shadow = 0, counter = 0, key_loaded = 0, FSM → K_IDLE. A simultaneous key_sin_valid is ignored.
- A new load while key_loaded = 1 keeps the old active key in use until the new commit; key_loaded stays 1.
- Effective key word: eff[j] = active[j] ^ GATE_POL[j].
- Data path, one register stage:
  - out_data = in_data ^ eff replicated to DATA_W; bit i uses eff[i mod KEY_W].
  - Latency is 1 cycle.
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer occurs when in_valid && in_ready; out_valid is set next cycle.
  - out_valid clears when out_ready is high and no new transfer occurs.
  - Full throughput: 1 word/cycle.
  - out_data and out_valid are held stable while out_valid && !out_ready.
- The key is sampled at capture time. A word already in the output register is not re-gated by a later commit or key_clear.
- With no committed key, data is still passed, gated by GATE_POL alone. This matches the wrong-key behaviour of the combinational RLL netlists; no lockout.
- Reset asserted mid-load or mid-transfer discards all state immediately.

Optional Feature:
- Macro: RLL_KEY_PARITY_EN.
- Defined:
  - After KEY_W bits the FSM enters K_PAR and accepts one extra key_sin bit, which must equal the even parity of the shadow.
  - Match → commit as above.
  - Mismatch → no commit, shadow cleared, key_err pulses 1 cycle, active key and key_loaded unchanged, return to K_IDLE.
- Undefined: K_PAR does not exist, key_err is tied to 0, and commit occurs on the KEY_W-th bit.

Test Plan:
- Reset values: after reset → key_loaded=0, key_busy=0, out_valid=0, in_ready=1; send in_data=0x12345678 with GATE_POL=0 → out_data=0x12345678 one cycle later.
- Key load: shift 0xA5A5A5A5 LSB-first with gaps of 0–3 idle cycles → key_loaded rises the cycle after bit 31; in_data=0x0000FFFF → out_data=0xA5A55A5A.
- Backpressure: key=0xFFFFFFFF, stream 0,1,2,3 with out_ready low for 3 cycles mid-stream → outputs 0xFFFFFFFF, 0xFFFFFFFE, 0xFFFFFFFD, 0xFFFFFFFC in order, no loss/duplication, stable while stalled.
- Clear race: key_clear coincident with key_sin_valid at bit 10 of a load → key_loaded=0, key_busy=0, a subsequent full 32-bit load commits correctly.
- Re-key in flight: a word captured with key 0x0000000F stalled in the output register while key 0x000000F0 commits → stalled word uses 0x0F and the next word uses 0xF0.
- Parity (RLL_KEY_PARITY_EN): 0x00000001 + parity bit 0 → key_err pulse, key_loaded unchanged; same key + parity bit 1 → committed.
